// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with an iterative logical shift-right.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 1101.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int CONST_W = 2,
    parameter int CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   alu_rs1,
    input  logic [WIDTH-1:0]   alu_rs2,
    input  logic [CONST_W-1:0] constant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_out,
    output logic               overflow,
    output logic               branch_taken_o,
    output logic               illegal_op,
    output logic               sticky_of,
    input  logic               sticky_clr,
    output logic               busy
);

    // state | meaning
    // IDLE  | no result pending, ready for a request
    // BUSY  | iterative op stepping one bit per cycle, inputs ignored
    // DONE  | result registers valid, waiting for hand-off
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_EQ0  = 4'b0101;
    localparam logic [3:0] OP_CMPH = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_CLR  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_PASS = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_SHR  = 4'b1110;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               handoff;
    logic [WIDTH-1:0]   c_ext;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     addi_full;
    logic [CNT_W-1:0]   shr_n;
    logic [WIDTH-1:0]   res_out;
    logic               res_of;
    logic               res_br;
    logic               res_ill;
    logic               start_iter;

`ifdef ALU_SEQ_MUL_EN
    logic               mul_q;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;

    // acc holds the multiplier, consumed LSB first while mcand walks left
    assign prod_next = prod + (acc[0] ? mcand : '0);
`endif

    assign c_ext     = {{(WIDTH-CONST_W){constant[CONST_W-1]}}, constant};
    assign add_full  = {1'b0, alu_rs1} + {1'b0, alu_rs2};
    assign addi_full = {1'b0, alu_rs1} + {1'b0, c_ext};
    assign shr_n     = CNT_W'(alu_rs2 % WIDTH_V);

    // DONE counts as idle once its result is leaving, so a new op can follow every cycle
    assign in_ready = rst_n && (state != BUSY) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign busy     = (state == BUSY);

    always_comb begin
        res_out    = '0;
        res_of     = 1'b0;
        res_br     = 1'b0;
        res_ill    = 1'b0;
        start_iter = 1'b0;
        case (opcode)
            OP_ADD:  {res_of, res_out} = add_full;
            OP_ADDI: {res_of, res_out} = addi_full;
            OP_SUB: begin
                res_out = alu_rs1 - alu_rs2;
                res_of  = (alu_rs1 < alu_rs2);
            end
            OP_SHL:  res_out = alu_rs1 << constant;
            OP_SLT:  res_out = {{(WIDTH-1){1'b0}}, ($signed(alu_rs1) < $signed(alu_rs2))};
            OP_EQ0:  res_br  = (alu_rs1 == '0);
            OP_CMPH: res_out = {{(WIDTH-1){1'b0}},
                                (alu_rs1[WIDTH-1:WIDTH/2] == alu_rs2[WIDTH-1:WIDTH/2])};
            OP_XOR:  res_out = alu_rs1 ^ alu_rs2;
            OP_CLR:  res_out = '0;
            OP_OR:   res_out = alu_rs1 | alu_rs2;
            OP_NOT:  res_out = ~alu_rs1;
            OP_JMP: begin
                res_out = alu_rs1;
                res_br  = 1'b1;
            end
            OP_PASS: res_out = alu_rs1;
            OP_SHR: begin
                if (shr_n == '0) res_out = alu_rs1;
                else             start_iter = 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  start_iter = 1'b1;
`else
            OP_MUL:  res_ill = 1'b1;
`endif
            default: res_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            out_valid      <= 1'b0;
            alu_out        <= '0;
            overflow       <= 1'b0;
            branch_taken_o <= 1'b0;
            illegal_op     <= 1'b0;
            sticky_of      <= 1'b0;
            acc            <= '0;
            cnt            <= '0;
`ifdef ALU_SEQ_MUL_EN
            mul_q          <= 1'b0;
            mcand          <= '0;
            prod           <= '0;
`endif
        end else begin
            if (handoff && overflow) sticky_of <= 1'b1;
            else if (sticky_clr)     sticky_of <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (accept && !start_iter) begin
                        state          <= DONE;
                        out_valid      <= 1'b1;
                        alu_out        <= res_out;
                        overflow       <= res_of;
                        branch_taken_o <= res_br;
                        illegal_op     <= res_ill;
                    end else if (accept) begin
                        state     <= BUSY;
                        out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        mul_q <= (opcode == OP_MUL);
                        acc   <= (opcode == OP_MUL) ? alu_rs2 : alu_rs1;
                        cnt   <= (opcode == OP_MUL) ? CNT_W'(WIDTH) : shr_n;
                        mcand <= {{WIDTH{1'b0}}, alu_rs1};
                        prod  <= '0;
`else
                        acc <= alu_rs1;
                        cnt <= shr_n;
`endif
                    end else if (handoff) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc <= acc >> 1;
                    cnt <= cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                    mcand <= mcand << 1;
                    prod  <= prod_next;
`endif
                    // last step: register the final value directly
                    if (cnt == CNT_W'(1)) begin
                        state          <= DONE;
                        out_valid      <= 1'b1;
                        branch_taken_o <= 1'b0;
                        illegal_op     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (mul_q) begin
                            alu_out  <= prod_next[WIDTH-1:0];
                            overflow <= |prod_next[2*WIDTH-1:WIDTH];
                        end else begin
                            alu_out  <= acc >> 1;
                            overflow <= 1'b0;
                        end
`else
                        alu_out  <= acc >> 1;
                        overflow <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor pops them on hand-off.
module tb_alu_seq;
    localparam int W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_EQ0  = 4'b0101;
    localparam logic [3:0] OP_CMPH = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_CLR  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_PASS = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_SHR  = 4'b1110;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic         overflow, branch_taken_o, illegal_op, sticky_of, sticky_clr, busy;
    logic [3:0]   opcode;
    logic [W-1:0] alu_rs1, alu_rs2, alu_out;
    logic [1:0]   constant;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] out;
        logic         of;
        logic         br;
        logic         ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_seq #(.WIDTH(W), .CONST_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .constant(constant),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .overflow(overflow), .branch_taken_o(branch_taken_o), .illegal_op(illegal_op),
        .sticky_of(sticky_of), .sticky_clr(sticky_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, queue its expected result.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] c, input logic [W-1:0] out,
                         input logic of, input logic br, input logic ill, input bit push);
        int   waited = 0;
        exp_t e;
        opcode   = op;
        alu_rs1  = a;
        alu_rs2  = b;
        constant = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout op%b: in_ready=0 after %0d cycles, expected 1", op, waited);
            in_valid = 1'b0;
        end else if (push) begin
            e = '{op, out, of, br, ill};
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every hand-off must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: out_valid=1 alu_out=%0h, expected no result", alu_out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result_op%b", e.op),
                          32'({alu_out, overflow, branch_taken_o, illegal_op}),
                          32'({e.out, e.of, e.br, e.ill}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint t0, t1;
        int     lat, lat_exp, seen, valid_cnt, drain;
        logic [3:0]   abort_op;
        logic [W-1:0] abort_a, abort_b;

        rst_n = 1'b0; in_valid = 1'b1; opcode = OP_ADD; alu_rs1 = 8'hF0; alu_rs2 = 8'h20;
        constant = 2'b00; out_ready = 1'b1; sticky_clr = 1'b0;

        // reset with a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({out_valid, alu_out, overflow, branch_taken_o, illegal_op, sticky_of, busy, in_ready}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'({in_ready, out_valid}), 32'(2'b10));

        // add with carry, sticky set on hand-off, then cleared
        @(posedge clk); #1;
        issue(OP_ADD, 8'hF0, 8'h20, 2'b00, 8'h10, 1, 0, 0, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("sticky_not_before_handoff", 32'(sticky_of), 0);
        @(negedge clk);
        check("sticky_set_on_handoff", 32'(sticky_of), 1);
        check("out_valid_drops_after_handoff", 32'(out_valid), 0);
        @(posedge clk); #1 sticky_clr = 1'b1;
        @(posedge clk); #1 sticky_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 32'(sticky_of), 0);

        // back-to-back single-cycle ops, one accepted per cycle
        @(posedge clk); #1;
        t0 = $time;
        issue(OP_XOR,  8'hAA, 8'h0F, 2'b00, 8'hA5, 0, 0, 0, 1);
        issue(OP_EQ0,  8'h00, 8'h12, 2'b00, 8'h00, 0, 1, 0, 1);
        issue(OP_JMP,  8'h33, 8'h00, 2'b00, 8'h33, 0, 1, 0, 1);
        issue(OP_SUB,  8'h10, 8'h20, 2'b00, 8'hF0, 1, 0, 0, 1);
        issue(OP_XOR,  8'h0F, 8'h0F, 2'b00, 8'h00, 0, 0, 0, 1);
        issue(OP_SLT,  8'hFF, 8'h01, 2'b00, 8'h01, 0, 0, 0, 1);
        issue(OP_SLT,  8'h01, 8'hFF, 2'b00, 8'h00, 0, 0, 0, 1);
        issue(OP_CMPH, 8'hA5, 8'hA0, 2'b00, 8'h01, 0, 0, 0, 1);
        issue(OP_CMPH, 8'hA5, 8'hB5, 2'b00, 8'h00, 0, 0, 0, 1);
        issue(OP_OR,   8'h50, 8'h05, 2'b00, 8'h55, 0, 0, 0, 1);
        issue(OP_NOT,  8'h0F, 8'h00, 2'b00, 8'hF0, 0, 0, 0, 1);
        issue(OP_CLR,  8'h77, 8'h66, 2'b00, 8'h00, 0, 0, 0, 1);
        issue(OP_SHL,  8'h03, 8'h00, 2'b10, 8'h0C, 0, 0, 0, 1);
        issue(OP_SHL,  8'h81, 8'h00, 2'b11, 8'h08, 0, 0, 0, 1);
        issue(OP_ADDI, 8'h10, 8'h00, 2'b01, 8'h11, 0, 0, 0, 1);
        issue(OP_PASS, 8'h7E, 8'h00, 2'b00, 8'h7E, 0, 0, 0, 1);
        issue(OP_EQ0,  8'h01, 8'h00, 2'b00, 8'h00, 0, 0, 0, 1);
        issue(OP_SHR,  8'h5A, 8'h08, 2'b00, 8'h5A, 0, 0, 0, 1);
        t1 = $time;
        in_valid = 1'b0;
        check("one_accept_per_cycle", 32'(t1 - t0), 32'(18 * 10));

        // overflow hand-off and clear in the same cycle: set wins
        @(posedge clk); #1 sticky_clr = 1'b1;
        issue(OP_ADD, 8'hFF, 8'h01, 2'b00, 8'h00, 1, 0, 0, 1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sticky_set_beats_clr", 32'(sticky_of), 1);
        @(negedge clk);
        check("sticky_clr_held", 32'(sticky_of), 0);

        // shr by 11 mod 8 = 3, result held while consumer stalls
        @(posedge clk); #1;
        sticky_clr = 1'b0; out_ready = 1'b0;
        issue(OP_SHR, 8'h80, 8'h0B, 2'b00, 8'h10, 0, 0, 0, 1);
        in_valid = 1'b0; alu_rs1 = 8'hFF; alu_rs2 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("shr_busy_cycle%0d", i + 1), 32'({busy, in_ready, out_valid}), 32'(3'b100));
        end
        @(negedge clk);
        check("shr_done_cycle4", 32'({busy, out_valid, alu_out}), 32'({1'b0, 1'b1, 8'h10}));
        @(negedge clk);
        check("shr_held_stalled", 32'({out_valid, in_ready, alu_out}), 32'({1'b1, 1'b0, 8'h10}));
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);

        // multiply (iterative) or illegal depending on build
        @(posedge clk); #1;
`ifdef ALU_SEQ_MUL_EN
        issue(OP_MUL, 8'h10, 8'h11, 2'b00, 8'h10, 1, 0, 0, 1);
        lat_exp = W + 1;
        abort_op = OP_MUL; abort_a = 8'h10; abort_b = 8'h11;
`else
        issue(OP_MUL, 8'h10, 8'h11, 2'b00, 8'h00, 0, 0, 1, 1);
        lat_exp = 1;
        abort_op = OP_SHR; abort_a = 8'hFF; abort_b = 8'h07;
`endif
        in_valid = 1'b0;
        lat = 0; seen = 0;
        while (seen == 0 && lat < 50) begin
            @(negedge clk);
            lat++;
            seen = out_valid ? 1 : 0;
        end
        check("mul_latency", 32'(lat), 32'(lat_exp));

        // reset on cycle 2 of an iterative op aborts it
        @(posedge clk); #1;
        issue(abort_op, abort_a, abort_b, 2'b00, 8'h00, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) valid_cnt++;
        end
        check("no_result_after_abort", 32'(valid_cnt), 0);
        check("idle_after_abort", 32'({busy, in_ready}), 32'(2'b01));

        // addi with negative immediate wraps with carry, then illegal opcode
        @(posedge clk); #1;
        issue(OP_ADDI, 8'h05, 8'h00, 2'b11, 8'h04, 1, 0, 0, 1);
        issue(OP_BAD,  8'h5A, 8'h3C, 2'b01, 8'h00, 0, 0, 1, 1);
        in_valid = 1'b0;

        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
